// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory bus: CPU-side requests and responder-side completion signals.
interface lc3b_mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_resp;
   logic        proto_err;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp, proto_err
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp, proto_err
   );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory bus: fixed-latency word
// read/write against an internal array, one transaction outstanding.
module lc3b_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   lc3b_mem_responder_if.slave  bus
);

   localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int WORDS    = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state;
   state_t                next_state;
   logic [CNT_BITS-1:0]   cnt;
   logic [CNT_BITS-1:0]   next_cnt;

   // Request copies taken at acceptance; later bus changes are ignored.
   logic                  cap_write;
   logic [ADDR_BITS-1:0]  cap_idx;
   logic [15:0]           cap_wdata;
   logic [1:0]            cap_be;

   logic [15:0]           mem_array [WORDS];
   logic [15:0]           rdata;
   logic                  proto_err;

   logic                  req;
   logic                  accept;
   logic                  enter_resp;
   logic                  txn_write;
   logic [ADDR_BITS-1:0]  txn_idx;
   logic [15:0]           txn_wdata;
   logic [1:0]            txn_be;

   // Byte offset and high address bits alias onto the same word.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{bus.mem_address[0], bus.mem_address[15:ADDR_BITS+1]};

   assign req    = bus.mem_read | bus.mem_write;
   assign accept = (state == IDLE) && req;

   // With LATENCY==1 RESP is entered straight from IDLE, so the live bus
   // values must be used; otherwise the captured copies are.
   assign txn_write = (state == IDLE) ? bus.mem_write                    : cap_write;
   assign txn_idx   = (state == IDLE) ? bus.mem_address[ADDR_BITS:1]     : cap_idx;
   assign txn_wdata = (state == IDLE) ? bus.mem_wdata                    : cap_wdata;
   assign txn_be    = (state == IDLE) ? bus.mem_byte_enable              : cap_be;

   assign enter_resp = !reset && (next_state == RESP) && (state != RESP);

   // State register and latency counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latch).
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               next_cnt   = CNT_BITS'(LATENCY - 1);
               next_state = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            next_cnt = cnt - CNT_BITS'(1);
            if (cnt == CNT_BITS'(1)) next_state = RESP;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture the request at acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_write <= bus.mem_write;
         cap_idx   <= bus.mem_address[ADDR_BITS:1];
         cap_wdata <= bus.mem_wdata;
         cap_be    <= bus.mem_byte_enable;
      end
   end

   // Read data register and sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata     <= 16'h0000;
         proto_err <= 1'b0;
      end else begin
         if (accept && bus.mem_read && bus.mem_write) proto_err <= 1'b1;
         if ((state == BUSY) && !req)                  proto_err <= 1'b1;
         if (enter_resp && !txn_write)                 rdata     <= mem_array[txn_idx];
      end
   end

   // Byte-lane write into the word array on the edge entering RESP.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch; contents survive reset and map to plain RAM.
      if (enter_resp && txn_write) begin
         if (txn_be[0]) mem_array[txn_idx][7:0]  <= txn_wdata[7:0];
         if (txn_be[1]) mem_array[txn_idx][15:8] <= txn_wdata[15:8];
      end
   end

   assign bus.mem_rdata = rdata;
   assign bus.mem_resp  = (state == RESP);
   assign bus.proto_err = proto_err;

endmodule
